vx_stream_rr_arb: RTL
=====================

Name: VX_stream_rr_arb

Overview:
- N-input, 1-output valid/ready stream arbiter with round-robin fairness.
- Selects one requester per cycle, steers its payload through the library N:1 data mux, and registers the result in a single-entry output stage.
- Shares one downstream consumer among several producers, e.g. cache/memory request ports or the issue-to-ALU path.
- Reports the winning index alongside the data so responses can be routed back.

Parameters:
- N, 4, number of requesters (>=1).
- DATAW, 32, payload width in bits.
- LN, LOG2UP(N), width of the index field (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  N  per-requester valid.
- data_in  in  N x DATAW  per-requester payload.
- ready_in  out  N  per-requester accept; one-hot or zero.
- valid_out  out  1  output stage holds a transfer.
- data_out  out  DATAW  registered payload.
- sel_out  out  LN  registered index of the requester that supplied data_out.
- ready_out  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): valid_out=0, data_out=0, sel_out=0, round-robin pointer ptr=0. While reset is high, ready_in=0.
- Transfer rules:
  - Input transfer on port i: valid_in[i] & ready_in[i].
  - Output transfer: valid_out & ready_out.
- Output stage state is EMPTY (valid_out=0) or FULL (valid_out=1).
  - stage_ready = ~valid_out | ready_out.
- Grant, combinational: the first i with valid_in[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - ready_in[i] = stage_ready & (i == grant) & valid_in[i].
  - At most one ready_in bit is set per cycle.
  - ready_in does not depend on valid_in of the requester itself beyond the grant; no combinational path from ready_out to valid_out.
- When a grant transfer occurs:
  - Next cycle: valid_out=1, data_out=data_in[grant], sel_out=grant.
  - ptr <= grant+1, wrapping N-1 -> 0.
- Output transfer with no new grant: valid_out <= 0. data_out and sel_out hold their last values.
- ready_out=0 while FULL: data_out and sel_out are held stable; ready_in=0 (no overwrite).
- Latency and throughput:
  - Latency from input transfer to valid_out: 1 cycle.
  - Throughput: 1 transfer/cycle when ready_out is held high (simultaneous output and input transfer in the same cycle keeps the stage FULL).
- ptr updates only on an input transfer. With no valid_in bits set, ptr holds.
- Fairness: with all N requesters continuously valid and ready_out=1, grants cycle 0,1,...,N-1,0,... For any set of continuously valid requesters, each waits at most N-1 accepted transfers.
- N=1: arbitration degenerates. ready_in[0]=stage_ready, sel_out is a constant 0, ptr is unused (tie off, mark unused).
- Non-power-of-two N: ptr wrap compares against N-1 explicitly, never relying on LN overflow.
- Reset mid-operation: a pending output transfer is dropped (valid_out=0 immediately). No input is accepted while reset is asserted.
- Producers must hold valid_in/data_in until accepted. The block does not check this; the bench asserts it.

Decomposition:
- No package needed; the only constants are the parameters.
- Sub-module VX_rr_grant (N, LN): inputs valid_in[N] and ptr[LN]; outputs grant index[LN] and grant_valid.
  - Purely combinational; implement as a double-width masked priority scan.
  - Reused by future schedulers.
- Data steering reuses the existing N:1 library mux (DATAW, N), with sel = grant.
- Top module holds the ptr register, the output stage registers, and the handshake logic.

Test Plan (N=4, DATAW=8 unless noted):
- Reset: assert reset mid-stream with valid_out=1 -> valid_out=0, sel_out=0, data_out=0, ready_in=0 asynchronously; after release, first grant starts at port 0.
- Full contention: valid_in=4'b1111, data_in[i]=8'hA0+i, ready_out=1 for 8 cycles -> sel_out sequence 0,1,2,3,0,1,2,3; data_out A0,A1,A2,A3,...; valid_out continuously 1 from cycle 1.
- Sparse requests and wrap: only ports 1 and 3 valid, ptr=2 -> grants 3,1,3,1; ptr wraps 3 -> 0 and skips the idle ports.
- Backpressure: stage FULL with sel_out=2 and data 8'h55, ready_out=0 for 5 cycles, all inputs valid -> data_out/sel_out stable, ready_in=0; when ready_out=1, next output is port 3.
- Idle: no valid_in -> valid_out drops 1 cycle after last output transfer; ptr unchanged; on next single request from port 0, it is granted regardless of ptr.
- Configs: N=1 (pass-through with 1-cycle latency, sel_out=0) and N=3 (wrap 2 -> 0) -> same fairness order and no X on sel_out.

Source files
------------

// File: rtl/vx_stream_rr_arb_pkg.sv
// rtl/vx_stream_rr_arb_pkg.sv - shared helpers for the stream round-robin arbiter slice
package vx_stream_rr_arb_pkg;

    // Index width for n entries; never below one bit so N=1 still has a sel field.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mux.sv
// rtl/vx_mux.sv - N:1 data mux over a flat payload bus
//
// Purpose: steer one DATAW slice of data_in to data_out.
// Ports:
//   data_in  [N*DATAW] concatenated payloads, entry i at bits i*DATAW +: DATAW
//   sel      [LN]      entry index; out-of-range selects zero
//   data_out [DATAW]   selected payload
module vx_mux
    import vx_stream_rr_arb_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int N     = 4,
    localparam int LN   = log2up(N)
) (
    input  logic [N*DATAW-1:0] data_in,
    input  logic [LN-1:0]      sel,
    output logic [DATAW-1:0]   data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == LN'(i)) begin
                data_out = data_in[i*DATAW +: DATAW];
            end
        end
    end

endmodule

// File: rtl/vx_rr_grant.sv
// rtl/vx_rr_grant.sv - combinational round-robin grant picker
//
// Purpose: pick the first set bit of valid_in scanning from ptr upward with wrap.
// Ports:
//   valid_in    [N]  requester valids
//   ptr         [LN] highest-priority index this cycle
//   grant       [LN] chosen index (0 when nothing is valid)
//   grant_valid      any requester valid
module vx_rr_grant #(
    parameter int N  = 4,
    parameter int LN = 2
) (
    input  logic [N-1:0]  valid_in,
    input  logic [LN-1:0] ptr,
    output logic [LN-1:0] grant,
    output logic          grant_valid
);

    // Scan a virtual 2N-wide copy of valid_in; entries below ptr in the lower
    // copy are masked off, so the upper copy supplies the wrapped-around part.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!grant_valid && valid_in[j % N] && (j >= int'(ptr))) begin
                grant       = LN'(j % N);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_stream_rr_arb.sv
// rtl/vx_stream_rr_arb.sv - N-input round-robin valid/ready stream arbiter
//
// Purpose: share one downstream consumer among N producers with round-robin
// fairness, a single registered output stage and the winning index on sel_out.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   valid_in  [N]         per-requester valid
//   data_in   [N*DATAW]   per-requester payload, entry i at bits i*DATAW +: DATAW
//   ready_in  [N]         per-requester accept, one-hot or zero
//   valid_out             output stage full
//   data_out  [DATAW]     registered payload
//   sel_out   [LN]        registered index of the requester behind data_out
//   ready_out             downstream accept
module vx_stream_rr_arb
    import vx_stream_rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int DATAW = 32,
    localparam int LN   = log2up(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       valid_in,
    input  logic [N*DATAW-1:0] data_in,
    output logic [N-1:0]       ready_in,
    output logic               valid_out,
    output logic [DATAW-1:0]   data_out,
    output logic [LN-1:0]      sel_out,
    input  logic               ready_out
);

    logic             stage_ready;
    logic             in_fire;
    logic [LN-1:0]    grant;
    logic [DATAW-1:0] grant_data;

    // Stage can take a new item when empty or when it drains this cycle.
    assign stage_ready = ~valid_out | ready_out;
    assign in_fire     = |(valid_in & ready_in);

    generate
        if (N == 1) begin : g_single
            // Single requester: no arbitration and no pointer to keep.
            assign grant    = '0;
            assign ready_in = stage_ready & ~reset;
        end else begin : g_multi
            logic [LN-1:0] ptr;
            logic          grant_valid;

            vx_rr_grant #(
                .N  (N),
                .LN (LN)
            ) u_grant (
                .valid_in    (valid_in),
                .ptr         (ptr),
                .grant       (grant),
                .grant_valid (grant_valid)
            );

            always_comb begin
                ready_in = '0;
                for (int i = 0; i < N; i++) begin
                    if (grant == LN'(i)) begin
                        ready_in[i] = stage_ready & grant_valid & ~reset;
                    end
                end
            end

            // Wrap is an explicit compare so non-power-of-two N never lands on
            // an index with no requester behind it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr <= '0;
                end else if (in_fire) begin
                    ptr <= (grant == LN'(N - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    endgenerate

    vx_mux #(
        .DATAW (DATAW),
        .N     (N)
    ) u_mux (
        .data_in  (data_in),
        .sel      (grant),
        .data_out (grant_data)
    );

    // Output stage: load on a grant transfer, empty on a drain with no refill,
    // otherwise hold data/sel steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= '0;
        end else if (in_fire) begin
            valid_out <= 1'b1;
            data_out  <= grant_data;
            sel_out   <= grant;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule
